// File: rtl/alarm_ctrl.sv
// Alarm stage: BCD setpoint, one-second edge detect from the RTC seconds byte, and a ring/snooze FSM driving the buzzer.
// Latency: RTC update to ringing is 2 cycles; strobes act on the next edge. There is no backpressure, and all outputs are registered.
module alarm_ctrl #(
  parameter int TONE_DIV   = 6000,
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sec_bcd,
  input  logic [7:0] min_bcd,
  input  logic [7:0] hour_bcd,
  input  logic       alarm_en,
  input  logic       set_valid,
  input  logic [7:0] set_hour,
  input  logic [7:0] set_min,
  input  logic       ack,
  input  logic       snooze,
  output logic       beep,
  output logic       ringing,
  output logic       snoozed,
  output logic [7:0] alarm_hour,
  output logic [7:0] alarm_min,
  output logic       set_err
);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  localparam int RW = $clog2(RING_SECS + 1);
  localparam int TW = $clog2(TONE_DIV + 1);
  localparam logic [RW-1:0] RING_LAST  = RW'(RING_SECS - 1);
  localparam logic [TW-1:0] TONE_LAST  = TW'(TONE_DIV - 1);
  localparam logic [3:0]    SNOOZE_LIM = 4'(MAX_SNOOZE);
  localparam logic [4:0]    SNOOZE_ADD = 5'(SNOOZE_MIN);

  state_t        state, state_nxt;
  logic [7:0]    sec_prev;
  logic          sec_tick;
  logic [RW-1:0] ring_cnt, ring_nxt;
  logic [TW-1:0] tone_cnt, tone_cnt_nxt;
  logic          tone, tone_nxt;
  logic [3:0]    snz_cnt, snz_nxt;
  logic [7:0]    tgt_hour, tgt_hour_nxt, tgt_min, tgt_min_nxt;
  logic          ring_start;
  logic          set_ok;

  logic [4:0] ones_sum, ones_adj;
  logic [3:0] m_ones, m_tens;
  logic [7:0] hour_inc, snz_hour, snz_min;

  // BCD snooze target: current time plus SNOOZE_MIN minutes, seconds implied 00
  always_comb begin
    ones_sum = {1'b0, min_bcd[3:0]} + SNOOZE_ADD;
    ones_adj = ones_sum - 5'd10;
    m_ones   = ones_sum[3:0];
    m_tens   = min_bcd[7:4];
    hour_inc = 8'h00;
    snz_hour = hour_bcd;
    snz_min  = min_bcd;
    if (ones_sum > 5'd9) begin
      m_ones = ones_adj[3:0];
      m_tens = min_bcd[7:4] + 4'd1;
    end
    if (hour_bcd[3:0] == 4'd9) hour_inc = {hour_bcd[7:4] + 4'd1, 4'd0};
    else                       hour_inc = {hour_bcd[7:4], hour_bcd[3:0] + 4'd1};
    if (hour_inc == 8'h24) hour_inc = 8'h00;
    if (m_tens == 4'd6) begin
      snz_min  = {4'd0, m_ones};
      snz_hour = hour_inc;
    end else begin
      snz_min  = {m_tens, m_ones};
      snz_hour = hour_bcd;
    end
  end

  always_comb begin
    set_ok = (set_hour[3:0] <= 4'd9) && (set_hour[7:4] <= 4'd9) &&
             (set_min[3:0]  <= 4'd9) && (set_min[7:4]  <= 4'd9) &&
             (set_hour <= 8'h23) && (set_min <= 8'h59);
  end

  // sec_prev holds the seconds value that caused the tick, so it stands in for sec_bcd here
  always_comb begin
    state_nxt    = state;
    ring_nxt     = ring_cnt;
    tone_cnt_nxt = tone_cnt;
    tone_nxt     = tone;
    snz_nxt      = snz_cnt;
    tgt_hour_nxt = tgt_hour;
    tgt_min_nxt  = tgt_min;
    ring_start   = 1'b0;
    case (state)
      IDLE: begin
        if (sec_tick && sec_prev == 8'h00 &&
            hour_bcd == alarm_hour && min_bcd == alarm_min) begin
          state_nxt  = RING;
          snz_nxt    = 4'd0;
          ring_start = 1'b1;
        end
      end
      RING: begin
        if (ack) begin
          state_nxt = IDLE;
        end else if (snooze && snz_cnt < SNOOZE_LIM) begin
          state_nxt    = SNOOZE;
          snz_nxt      = snz_cnt + 4'd1;
          tgt_hour_nxt = snz_hour;
          tgt_min_nxt  = snz_min;
        end else if (sec_tick) begin
          if (ring_cnt == RING_LAST) state_nxt = IDLE;
          else                       ring_nxt  = ring_cnt + 1'b1;
        end
      end
      SNOOZE: begin
        if (ack) begin
          state_nxt = IDLE;
        end else if (sec_tick && sec_prev == 8'h00 &&
                     hour_bcd == tgt_hour && min_bcd == tgt_min) begin
          state_nxt  = RING;
          ring_start = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!alarm_en) begin
      state_nxt  = IDLE;
      ring_start = 1'b0;
    end
    if (ring_start) begin
      ring_nxt     = '0;
      tone_cnt_nxt = '0;
      tone_nxt     = 1'b1;
    end else if (state == RING) begin
      if (tone_cnt == TONE_LAST) begin
        tone_cnt_nxt = '0;
        tone_nxt     = ~tone;
      end else begin
        tone_cnt_nxt = tone_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sec_prev   <= 8'h00;
      sec_tick   <= 1'b0;
      ring_cnt   <= '0;
      tone_cnt   <= '0;
      tone       <= 1'b0;
      snz_cnt    <= 4'd0;
      tgt_hour   <= 8'h00;
      tgt_min    <= 8'h00;
      alarm_hour <= 8'h07;
      alarm_min  <= 8'h00;
      set_err    <= 1'b0;
      beep       <= 1'b0;
      ringing    <= 1'b0;
      snoozed    <= 1'b0;
    end else begin
      state    <= state_nxt;
      sec_prev <= sec_bcd;
      sec_tick <= (sec_bcd != sec_prev);
      ring_cnt <= ring_nxt;
      tone_cnt <= tone_cnt_nxt;
      tone     <= tone_nxt;
      snz_cnt  <= snz_nxt;
      tgt_hour <= tgt_hour_nxt;
      tgt_min  <= tgt_min_nxt;
      set_err  <= set_valid && !set_ok;
      if (set_valid && set_ok) begin
        alarm_hour <= set_hour;
        alarm_min  <= set_min;
      end
      beep    <= (state_nxt == RING) && tone_nxt && !ring_nxt[0];
      ringing <= (state_nxt == RING);
      snoozed <= (state_nxt == SNOOZE);
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: stimulus queues timed expectations, a negedge monitor compares them.
module tb_alarm_ctrl;
  localparam int TD = 6000;

  logic       clk = 1'b0;
  logic       rst, alarm_en, set_valid, ack, snooze;
  logic [7:0] sec_bcd, min_bcd, hour_bcd, set_hour, set_min;
  logic       beep, ringing, snoozed, set_err;
  logic [7:0] alarm_hour, alarm_min;

  always #5 clk = ~clk;

  alarm_ctrl dut (
    .clk(clk), .rst(rst), .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hour_bcd(hour_bcd),
    .alarm_en(alarm_en), .set_valid(set_valid), .set_hour(set_hour), .set_min(set_min),
    .ack(ack), .snooze(snooze), .beep(beep), .ringing(ringing), .snoozed(snoozed),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .set_err(set_err)
  );

  typedef struct {
    int          due;
    string       tag;
    logic [27:0] val;
    logic [27:0] mask;
  } exp_t;

  localparam logic [27:0] M_ALL   = 28'hFFFFFFF;
  localparam logic [27:0] M_FLAGS = 28'hF000000;
  localparam logic [27:0] M_BR    = 28'hC000000;
  localparam logic [27:0] M_SET   = 28'h1FFFFFF;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t keep[$];
  wire [27:0] obs = {beep, ringing, snoozed, set_err, alarm_hour, alarm_min};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].due == cyc) begin
        n_chk++;
        if ((obs & sb[i].mask) !== (sb[i].val & sb[i].mask)) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h (mask %h) cycle %0d",
                   sb[i].tag, obs & sb[i].mask, sb[i].val & sb[i].mask, sb[i].mask, cyc);
        end
      end else if (sb[i].due < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s: check missed, due %0d now %0d", sb[i].tag, sb[i].due, cyc);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  function automatic logic [27:0] pk(input logic b, input logic r, input logic s, input logic e,
                                     input logic [7:0] h, input logic [7:0] m);
    return {b, r, s, e, h, m};
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic expect_at(input int d, input string tag, input logic [27:0] v, input logic [27:0] m);
    exp_t e;
    e.due = cyc + d; e.tag = tag; e.val = v; e.mask = m;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    hour_bcd = h; min_bcd = m; sec_bcd = s;
  endtask

  task automatic set_cmd(input logic [7:0] h, input logic [7:0] m);
    set_valid = 1'b1; set_hour = h; set_min = m;
    step(1);
    set_valid = 1'b0;
  endtask

  task automatic pulse(input logic a, input logic s);
    ack = a; snooze = s;
    step(1);
    ack = 1'b0; snooze = 1'b0;
  endtask

  // alarm must be 23:57; walks the RTC across the match minute
  task automatic ring_up(input string tag);
    set_time(8'h23, 8'h56, 8'h59);
    step(3);
    set_time(8'h23, 8'h57, 8'h00);
    expect_at(1, {tag, "_pre"}, pk(0, 0, 0, 0, 0, 0), M_BR);
    expect_at(2, tag, pk(1, 1, 0, 0, 0, 0), M_FLAGS);
    step(3);
  endtask

  task automatic snooze_to(input logic [7:0] h, input logic [7:0] m, input string tag);
    set_time(h, bcd(int'(m[7:4]) * 10 + int'(m[3:0]) - 1), 8'h59);
    step(3);
    set_time(h, m, 8'h00);
    expect_at(1, {tag, "_wait"}, pk(0, 0, 1, 0, 0, 0), M_FLAGS);
    expect_at(2, tag, pk(1, 1, 0, 0, 0, 0), M_FLAGS);
    step(3);
  endtask

  initial begin
    rst = 1'b1; alarm_en = 1'b1; set_valid = 1'b0; ack = 1'b0; snooze = 1'b0;
    set_hour = 8'h00; set_min = 8'h00;
    set_time(8'h07, 8'h29, 8'h59);
    step(2);
    expect_at(0, "reset", pk(0, 0, 0, 0, 8'h07, 8'h00), M_ALL);
    rst = 1'b0;
    step(3);

    expect_at(1, "set_rej_h24", pk(0, 0, 0, 1, 8'h07, 8'h00), M_SET);
    expect_at(2, "set_err_clear", pk(0, 0, 0, 0, 8'h07, 8'h00), M_SET);
    set_cmd(8'h24, 8'h00);
    step(2);
    expect_at(1, "set_rej_m5a", pk(0, 0, 0, 1, 8'h07, 8'h00), M_SET);
    set_cmd(8'h12, 8'h5A);
    step(2);
    expect_at(1, "set_rej_h0a", pk(0, 0, 0, 1, 8'h07, 8'h00), M_SET);
    set_cmd(8'h0A, 8'h00);
    step(2);
    expect_at(1, "set_0730", pk(0, 0, 0, 0, 8'h07, 8'h30), M_SET);
    set_cmd(8'h07, 8'h30);
    step(3);

    set_time(8'h07, 8'h30, 8'h00);
    expect_at(1, "ring_pre", pk(0, 0, 0, 0, 0, 0), M_BR);
    expect_at(2, "ring_0730", pk(1, 1, 0, 0, 0, 0), M_FLAGS);
    expect_at(1 + TD, "tone_hi_end", pk(1, 1, 0, 0, 0, 0), M_BR);
    expect_at(2 + TD, "tone_lo", pk(0, 1, 0, 0, 0, 0), M_BR);
    expect_at(1 + 2 * TD, "tone_lo_end", pk(0, 1, 0, 0, 0, 0), M_BR);
    expect_at(2 + 2 * TD, "tone_hi2", pk(1, 1, 0, 0, 0, 0), M_BR);
    step(2 * TD + 5);
    expect_at(1, "ack_stop", pk(0, 0, 0, 0, 0, 0), M_FLAGS);
    pulse(1'b1, 1'b0);
    step(2);

    expect_at(1, "set_2357", pk(0, 0, 0, 0, 8'h23, 8'h57), M_SET);
    set_cmd(8'h23, 8'h57);
    step(2);
    ring_up("ring_2357");
    expect_at(1, "snooze1", pk(0, 0, 1, 0, 0, 0), M_FLAGS);
    pulse(1'b0, 1'b1);
    step(2);
    snooze_to(8'h00, 8'h02, "resume_0002");
    expect_at(1, "snooze2", pk(0, 0, 1, 0, 0, 0), M_FLAGS);
    pulse(1'b0, 1'b1);
    step(2);
    snooze_to(8'h00, 8'h07, "resume_0007");
    expect_at(1, "snooze3", pk(0, 0, 1, 0, 0, 0), M_FLAGS);
    pulse(1'b0, 1'b1);
    step(2);
    snooze_to(8'h00, 8'h12, "resume_0012");
    expect_at(1, "snooze4_ignored", pk(1, 1, 0, 0, 0, 0), M_FLAGS);
    pulse(1'b0, 1'b1);
    step(2);
    expect_at(1, "ack_after_snz", pk(0, 0, 0, 0, 0, 0), M_FLAGS);
    pulse(1'b1, 1'b0);
    step(2);

    ring_up("ring_both");
    expect_at(1, "ack_snooze_same", pk(0, 0, 0, 0, 0, 0), M_FLAGS);
    expect_at(3, "ack_snooze_hold", pk(0, 0, 0, 0, 0, 0), M_FLAGS);
    pulse(1'b1, 1'b1);
    step(4);

    ring_up("ring_timeout");
    for (int k = 1; k <= 60; k++) begin
      if (k < 60) set_time(8'h23, 8'h57, bcd(k));
      else        set_time(8'h23, 8'h58, 8'h00);
      if (k == 1)  expect_at(2, "gate_sec1_off", pk(0, 1, 0, 0, 0, 0), M_FLAGS);
      if (k == 2)  expect_at(2, "gate_sec2_on", pk(1, 1, 0, 0, 0, 0), M_FLAGS);
      if (k == 59) expect_at(2, "gate_sec59_off", pk(0, 1, 0, 0, 0, 0), M_FLAGS);
      if (k == 60) begin
        expect_at(1, "timeout_pre", pk(0, 1, 0, 0, 0, 0), M_BR);
        expect_at(2, "timeout_idle", pk(0, 0, 0, 0, 0, 0), M_FLAGS);
      end
      step(4);
    end

    alarm_en = 1'b0;
    set_time(8'h23, 8'h56, 8'h59);
    step(3);
    set_time(8'h23, 8'h57, 8'h00);
    expect_at(2, "en_off_match", pk(0, 0, 0, 0, 0, 0), M_FLAGS);
    expect_at(4, "en_off_hold", pk(0, 0, 0, 0, 0, 0), M_FLAGS);
    step(5);
    alarm_en = 1'b1;
    expect_at(3, "en_back_noring", pk(0, 0, 0, 0, 0, 0), M_FLAGS);
    step(4);
    ring_up("ring_en_drop");
    alarm_en = 1'b0;
    expect_at(1, "en_drop_idle", pk(0, 0, 0, 0, 0, 0), M_FLAGS);
    step(1);
    alarm_en = 1'b1;
    step(3);

    expect_at(1, "set_1015", pk(0, 0, 0, 0, 8'h10, 8'h15), M_SET);
    set_cmd(8'h10, 8'h15);
    step(1);
    expect_at(1, "set_2357_again", pk(0, 0, 0, 0, 8'h23, 8'h57), M_SET);
    set_cmd(8'h23, 8'h57);
    step(2);
    ring_up("ring_rst");
    rst = 1'b1;
    expect_at(1, "rst_midring", pk(0, 0, 0, 0, 8'h07, 8'h00), M_ALL);
    step(1);
    rst = 1'b0;
    step(3);

    for (int i = 0; i < 100 && sb.size() != 0; i++) step(1);
    if (sb.size() != 0) begin
      foreach (sb[i]) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s: never evaluated, due %0d", sb[i].tag, sb[i].due);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
